// File: rtl/key_led_array.sv
// key_led_array
//   N independent key/switch channels. Each raw input is synchronized,
//   debounced, and turned into a registered LED output plus a one-clock
//   rising-edge event.
//
//   Output behaviour (MODE, shared by all channels):
//     0 = follow  : out tracks the debounced level
//     1 = toggle  : out inverts on every debounced rising edge
//     2 = pulse   : out is high for PULSE_CYCLES clocks after each rising
//                   edge; a new edge during a pulse restarts the count
//     any other value behaves as follow.
//
//   Build option: define KEY_LED_ARRAY_ACTIVE_LOW_EN for active-low inputs.
//   The inputs are then inverted ahead of the synchronizer, so everything
//   downstream, including the synchronizer reset value, uses active-high.
//
//   Ports
//     clk      system clock, all state on the rising edge
//     rst      asynchronous, active-high reset
//     in[N]    raw asynchronous channel inputs
//     out[N]   registered per-channel outputs
//     evt[N]   registered one-clock pulse per debounced rising edge
module key_led_array #(
   parameter int N            = 2,
   parameter int DEB_CYCLES   = 4,
   parameter int MODE         = 0,
   parameter int PULSE_CYCLES = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in,
   output logic [N-1:0] out,
   output logic [N-1:0] evt
);

   localparam int            CW       = $clog2(DEB_CYCLES) + 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
   // Unsupported mode values fall back to follow.
   localparam int            MODE_EFF = (MODE == 1 || MODE == 2) ? MODE : 0;

   logic [N-1:0] in_act;

`ifdef KEY_LED_ARRAY_ACTIVE_LOW_EN
   assign in_act = ~in;
`else
   assign in_act = in;
`endif

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_ch
         logic          sync1_q;
         logic          sync2_q;
         logic          deb_q;
         logic          deb_d;
         logic          rise_d;
         logic          evt_q;
         logic          out_q;
         logic          out_d;
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // The counter runs only while the synchronized input disagrees
         // with the debounced level; any agreement clears it, so a short
         // excursion never accumulates toward a change.
         always_comb begin
            deb_d  = deb_q;
            cnt_d  = '0;
            rise_d = 1'b0;
            if (sync2_q != deb_q) begin
               if (cnt_q == DEB_LAST) begin
                  deb_d  = sync2_q;
                  rise_d = sync2_q;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               deb_q   <= 1'b0;
               cnt_q   <= '0;
               evt_q   <= 1'b0;
               out_q   <= 1'b0;
            end else begin
               sync1_q <= in_act[gi];
               sync2_q <= sync1_q;
               deb_q   <= deb_d;
               cnt_q   <= cnt_d;
               evt_q   <= rise_d;
               out_q   <= out_d;
            end
         end

         if (MODE_EFF == 2) begin : g_pulse
            localparam int            PW         = $clog2(PULSE_CYCLES + 1);
            localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES);

            logic [PW-1:0] pcnt_q;
            logic [PW-1:0] pcnt_d;

            // A rising edge always reloads, which stretches an active
            // pulse without a low gap; otherwise count down to zero.
            always_comb begin
               pcnt_d = '0;
               if (rise_d) begin
                  pcnt_d = PULSE_LOAD;
               end else if (pcnt_q != '0) begin
                  pcnt_d = pcnt_q - PW'(1);
               end
            end

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  pcnt_q <= '0;
               end else begin
                  pcnt_q <= pcnt_d;
               end
            end

            assign out_d = (pcnt_d != '0);
         end else if (MODE_EFF == 1) begin : g_toggle
            assign out_d = out_q ^ rise_d;
         end else begin : g_follow
            assign out_d = deb_d;
         end

         assign out[gi] = out_q;
         assign evt[gi] = evt_q;
      end
   endgenerate

endmodule

// File: tb/tb_key_led_array.sv
// tb_key_led_array
//   Four instances with N=2, DEB_CYCLES=4: MODE 0, 1, 2 (PULSE_CYCLES=8)
//   and MODE 3, which must act like MODE 0 and shares its inputs.
//   Stimulus values are written in active-high terms and converted to the
//   physical polarity, so the same tables apply with
//   KEY_LED_ARRAY_ACTIVE_LOW_EN defined.
module tb_key_led_array;

`ifdef KEY_LED_ARRAY_ACTIVE_LOW_EN
   localparam logic [1:0] POL = 2'b11;
`else
   localparam logic [1:0] POL = 2'b00;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] in0, in1, in2;
   logic [1:0] pin0, pin1, pin2;
   logic [1:0] out0, evt0, out1, evt1, out2, evt2, out3, evt3;

   assign pin0 = in0 ^ POL;
   assign pin1 = in1 ^ POL;
   assign pin2 = in2 ^ POL;

   key_led_array #(.N(2), .DEB_CYCLES(4), .MODE(0), .PULSE_CYCLES(8)) u0 (
      .clk(clk), .rst(rst), .in(pin0), .out(out0), .evt(evt0));
   key_led_array #(.N(2), .DEB_CYCLES(4), .MODE(1), .PULSE_CYCLES(8)) u1 (
      .clk(clk), .rst(rst), .in(pin1), .out(out1), .evt(evt1));
   key_led_array #(.N(2), .DEB_CYCLES(4), .MODE(2), .PULSE_CYCLES(8)) u2 (
      .clk(clk), .rst(rst), .in(pin2), .out(out2), .evt(evt2));
   key_led_array #(.N(2), .DEB_CYCLES(4), .MODE(3), .PULSE_CYCLES(8)) u3 (
      .clk(clk), .rst(rst), .in(pin0), .out(out3), .evt(evt3));

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         unit;
      logic [1:0] v;
      int         hold;
      logic [1:0] eo;
      int         ev0;
      int         ev1;
      int         hi0;
      int         hi1;
   } seg_t;

   typedef struct {
      int         unit;
      logic [1:0] eo;
      logic [1:0] ee;
      string      tag;
   } cyc_t;

   seg_t segs[$];
   seg_t seg_sb[$];
   cyc_t cyc_sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end else begin
         $display("ok   %s value=%0d", name, act);
      end
   endtask

   // {out[1:0], evt[1:0]} of one instance
   function automatic logic [3:0] oe(input int u);
      case (u)
         0:       return {out0, evt0};
         1:       return {out1, evt1};
         2:       return {out2, evt2};
         default: return {out3, evt3};
      endcase
   endfunction

   task automatic set_in(input int u, input logic [1:0] v);
      case (u)
         0:       in0 = v;
         1:       in1 = v;
         default: in2 = v;
      endcase
   endtask

   // One clock: drive, queue expectation, compare after the edge.
   task automatic cycle(input int u, input logic [1:0] v, input logic [1:0] eo,
                        input logic [1:0] ee, input string tag);
      cyc_t c;
      logic [3:0] r;
      set_in(u, v);
      cyc_sb.push_back('{u, eo, ee, tag});
      @(posedge clk);
      #1;
      c = cyc_sb.pop_front();
      r = oe(c.unit);
      chk($sformatf("%s u%0d out", c.tag, c.unit), r[3:2], c.eo);
      chk($sformatf("%s u%0d evt", c.tag, c.unit), r[1:0], c.ee);
      if (c.unit == 0) begin
         r = oe(3);
         chk($sformatf("%s u3 out", c.tag), r[3:2], c.eo);
         chk($sformatf("%s u3 evt", c.tag), r[1:0], c.ee);
      end
   endtask

   // Hold one input value for a number of clocks, then compare final
   // output plus event and high-cycle counts accumulated over the span.
   task automatic run_seg(input int idx, input seg_t s);
      int   units[$];
      int   ev0[4], ev1[4], hi0[4], hi1[4];
      seg_t e;
      logic [3:0] r;
      units.push_back(s.unit);
      if (s.unit == 0) units.push_back(3);
      for (int u = 0; u < 4; u++) begin
         ev0[u] = 0; ev1[u] = 0; hi0[u] = 0; hi1[u] = 0;
      end
      set_in(s.unit, s.v);
      seg_sb.push_back(s);
      for (int k = 0; k < s.hold; k++) begin
         @(posedge clk);
         #1;
         foreach (units[j]) begin
            r = oe(units[j]);
            ev0[units[j]] += int'(r[0]);
            ev1[units[j]] += int'(r[1]);
            hi0[units[j]] += int'(r[2]);
            hi1[units[j]] += int'(r[3]);
         end
      end
      e = seg_sb.pop_front();
      foreach (units[j]) begin
         r = oe(units[j]);
         chk($sformatf("seg%0d u%0d in=%b out", idx, units[j], e.v), r[3:2], e.eo);
         chk($sformatf("seg%0d u%0d evt0 count", idx, units[j]), ev0[units[j]], e.ev0);
         chk($sformatf("seg%0d u%0d evt1 count", idx, units[j]), ev1[units[j]], e.ev1);
         chk($sformatf("seg%0d u%0d out0 high", idx, units[j]), hi0[units[j]], e.hi0);
         chk($sformatf("seg%0d u%0d out1 high", idx, units[j]), hi1[units[j]], e.hi1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      logic [1:0] v;

      // unit, in, hold, final out, evt0 count, evt1 count, out0 high, out1 high
      segs = '{
         // follow: press, release, 3-clock glitch, 4-clock minimum press
         '{0, 2'b01,  8, 2'b01, 1, 0, 3, 0},
         '{0, 2'b00,  8, 2'b00, 0, 0, 5, 0},
         '{0, 2'b01,  3, 2'b00, 0, 0, 0, 0},
         '{0, 2'b00,  8, 2'b00, 0, 0, 0, 0},
         '{0, 2'b01,  4, 2'b00, 0, 0, 0, 0},
         '{0, 2'b00,  8, 2'b00, 1, 0, 4, 0},
         '{0, 2'b11,  8, 2'b11, 1, 1, 3, 3},
         '{0, 2'b10,  8, 2'b10, 0, 0, 5, 8},
         '{0, 2'b00,  8, 2'b00, 0, 0, 0, 5},
         // toggle: two press/release cycles on ch0, then one on ch1
         '{1, 2'b01, 10, 2'b01, 1, 0, 5, 0},
         '{1, 2'b00, 10, 2'b01, 0, 0, 10, 0},
         '{1, 2'b01, 10, 2'b00, 1, 0, 5, 0},
         '{1, 2'b00, 10, 2'b00, 0, 0, 0, 0},
         '{1, 2'b10, 10, 2'b10, 0, 1, 0, 5},
         '{1, 2'b00, 10, 2'b10, 0, 0, 0, 10},
         // pulse: single press gives exactly 8 high clocks, release is silent
         '{2, 2'b10, 20, 2'b00, 0, 1, 0, 8},
         '{2, 2'b00, 12, 2'b00, 0, 0, 0, 0}
      };

      rst = 1'b1;
      in0 = 2'b00; in1 = 2'b00; in2 = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 4; u++) begin
         r = oe(u);
         chk($sformatf("reset u%0d out", u), r[3:2], 2'b00);
         chk($sformatf("reset u%0d evt", u), r[1:0], 2'b00);
      end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Exact latency: out and evt rise on the 6th edge, evt for one clock.
      for (int k = 1; k <= 8; k++)
         cycle(0, 2'b01, (k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, $sformatf("lat_rise e%0d", k));
      for (int k = 1; k <= 8; k++)
         cycle(0, 2'b00, (k >= 6) ? 2'b00 : 2'b01, 2'b00, $sformatf("lat_fall e%0d", k));

      foreach (segs[i]) run_seg(i, segs[i]);

      // Pulse extension: second qualified press arrives as early as the
      // debouncer allows (8 clocks after the first), so the reload keeps
      // out[1] high for 16 contiguous clocks.
      for (int k = 1; k <= 28; k++) begin
         v = (k <= 4 || (k >= 9 && k <= 12)) ? 2'b10 : 2'b00;
         cycle(2, v, (k >= 6 && k <= 21) ? 2'b10 : 2'b00,
               (k == 6 || k == 14) ? 2'b10 : 2'b00, $sformatf("extend e%0d", k));
      end

      // Reset mid-debounce in toggle mode.
      for (int k = 1; k <= 3; k++)
         cycle(1, 2'b01, 2'b10, 2'b00, $sformatf("pre_rst e%0d", k));
      rst = 1'b1;
      #1;
      r = oe(1);
      chk("rst_async u1 out", r[3:2], 2'b00);
      chk("rst_async u1 evt", r[1:0], 2'b00);
      repeat (2) begin
         @(posedge clk);
         #1;
         r = oe(1);
         chk("rst_hold u1 out", r[3:2], 2'b00);
         chk("rst_hold u1 evt", r[1:0], 2'b00);
      end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++)
         cycle(1, 2'b01, (k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, $sformatf("post_rst e%0d", k));

      // Reset mid-pulse: pulse is abandoned and does not resume.
      for (int k = 1; k <= 8; k++)
         cycle(2, 2'b01, (k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, $sformatf("pulse_pre e%0d", k));
      rst = 1'b1;
      in2 = 2'b00;
      #1;
      r = oe(2);
      chk("rst_pulse u2 out", r[3:2], 2'b00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 1; k <= 10; k++)
         cycle(2, 2'b00, 2'b00, 2'b00, $sformatf("pulse_post e%0d", k));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
